// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks: FSM states and
// the shift-and-add-3 digit constants.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit double-dabble correction: a digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next decade.
// Inputs are always <= 9, so the result never exceeds 12 and fits in 4 bits.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // add-3 correction for digits at or above the threshold
  always_comb begin
    dout = din;
    if (din >= BCD_ADJ_THRESH) begin
      dout = din + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// A start in IDLE captures value; WIDTH cycles later bcd is updated and done
// pulses. bcd holds between conversions so the display never sees partial data.
module bcd_serial_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              value,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int REG_W = BCD_W + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [REG_W-1:0] sreg;
  logic [REG_W-1:0] adj;
  logic [REG_W-1:0] shifted;
  logic             last;

  // Working register: BCD digits in the upper bits, binary operand below.
  // Each digit is corrected independently before the whole register shifts.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (sreg[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .dout (adj [WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  assign adj[WIDTH-1:0] = sreg[WIDTH-1:0];
  assign shifted        = adj << 1;
  assign last           = (state == SHIFT) && (cnt == CNT_W'(1));
  assign busy           = (state == SHIFT);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state logic: starts are only honoured while idle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (last)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // datapath: load, shift/adjust, and publish the result on the final shift
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sreg <= '0;
      bcd  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg <= {{BCD_W{1'b0}}, value};
            cnt  <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          sreg <= shifted;
          cnt  <= cnt - CNT_W'(1);
          if (last) begin
            bcd  <= shifted[REG_W-1:WIDTH];
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
